rr_encoder16_4: RTL

Registered 16-to-4 round-robin request encoder, the inverse of the 4-to-16 decoder. It collapses up to 16 concurrent request lines into one 4-bit index, with a valid/ready handshake toward the consumer. One-hot grant feedback goes back to the requesters. It arbitrates shared-resource requests (interrupt sources, memory-port clients) ahead of the CompactRISC16 datapath.

---
 rtl/rr_encoder16_4_pkg.sv | 15 +
 rtl/rr_encoder16_4_if.sv | 22 ++
 rtl/rr_encoder16_4_decoder4_16.sv | 16 +
 rtl/rr_encoder16_4.sv | 78 +++++++
 4 files changed

// File: rtl/rr_encoder16_4_pkg.sv
// ----------------------------------------------------------------------------
// rr_encoder16_4_pkg : shared widths and state encoding for rr_encoder16_4
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rr_encoder16_4_pkg;
  localparam int REQ_WIDTH = 16;
  localparam int IDX_WIDTH = 4;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
endpackage

`default_nettype wire

// File: rtl/rr_encoder16_4_if.sv
// ----------------------------------------------------------------------------
// rr_encoder16_4_if : request / grant handshake bundle for rr_encoder16_4
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface rr_encoder16_4_if;
  import rr_encoder16_4_pkg::*;

  logic [REQ_WIDTH-1:0] i_req;
  logic                 i_ready;
  logic                 o_valid;
  logic [IDX_WIDTH-1:0] o_index;
  logic [REQ_WIDTH-1:0] o_grant;

  modport master (output i_req, output i_ready,
                  input  o_valid, input o_index, input o_grant);
  modport slave  (input  i_req, input i_ready,
                  output o_valid, output o_index, output o_grant);
endinterface

`default_nettype wire

// File: rtl/rr_encoder16_4_decoder4_16.sv
// ----------------------------------------------------------------------------
// decoder4_16 : 4-to-16 one-hot decoder
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module decoder4_16
  import rr_encoder16_4_pkg::*;
(
  input  wire logic [IDX_WIDTH-1:0] i_sel,
  output logic      [REQ_WIDTH-1:0] o_dec
);
  assign o_dec = REQ_WIDTH'(1) << i_sel;
endmodule

`default_nettype wire

// File: rtl/rr_encoder16_4.sv
// ----------------------------------------------------------------------------
// rr_encoder16_4 : registered 16-to-4 round-robin request encoder with
//                  valid/ready handshake and one-hot grant feedback
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_encoder16_4
  import rr_encoder16_4_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
)(
  input  wire logic          i_clk,
  input  wire logic          i_reset,
  rr_encoder16_4_if.slave    bus
);

  logic [0:0]           r_state;
  logic [IDX_WIDTH-1:0] r_index;
  logic [IDX_WIDTH-1:0] r_ptr;

  logic                 w_xfer;
  logic                 w_load;
  logic                 w_any;
  logic [IDX_WIDTH-1:0] w_base;
  logic [IDX_WIDTH-1:0] w_winner;
  logic [REQ_WIDTH-1:0] w_dec;

  // Descending scan so the smallest offset from base is the last to overwrite.
  function automatic logic [IDX_WIDTH-1:0] f_find_first(
    input logic [REQ_WIDTH-1:0] req,
    input logic [IDX_WIDTH-1:0] base
  );
    logic [IDX_WIDTH-1:0] pos;
    f_find_first = base;
    for (int k = REQ_WIDTH - 1; k >= 0; k--) begin
      pos = base + IDX_WIDTH'(k);
      if (req[pos]) f_find_first = pos;
    end
  endfunction

  assign w_xfer   = (r_state == GRANT) && bus.i_ready;
  assign w_load   = (r_state == IDLE) || w_xfer;
  assign w_any    = |bus.i_req;
  assign w_base   = !ROUND_ROBIN        ? '0 :
                    (r_state == GRANT)  ? r_index + IDX_WIDTH'(1) : r_ptr;
  assign w_winner = f_find_first(bus.i_req, w_base);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_index <= '0;
      r_ptr   <= '0;
    end else begin
      if (w_xfer) r_ptr <= r_index + IDX_WIDTH'(1);
      if (w_load) begin
        if (w_any) begin
          r_state <= GRANT;
          r_index <= w_winner;
        end else begin
          r_state <= IDLE;
        end
      end
    end
  end

  decoder4_16 u_dec (
    .i_sel (r_index),
    .o_dec (w_dec)
  );

  assign bus.o_valid = r_state;
  assign bus.o_index = r_index;
  assign bus.o_grant = w_dec & {REQ_WIDTH{r_state}};

endmodule

`default_nettype wire
